dvp_pll_ctrl: RTL and testbench

DVP_PLL_CTRL -- requirements
Module: dvp_pll_ctrl

---
 rtl/dvp_pll_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dvp_pll_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pll_ctrl.sv
// ---------------------------------------------------------------------------
// dvp_pll_ctrl
//
// Bring-up and supervision controller for a PLL that feeds several downstream
// clock domains. The controller pulses the PLL reset, waits for lock, requires
// the lock to stay up for a qualification window, and then releases the
// per-domain resets one at a time. A lock loss while running tears the domains
// back down and restarts the PLL. Repeated failure to lock parks the block in
// a FAIL state until software asks for a retry.
//
// Ports
//   ref_clk     in   PLL reference clock, the only clock of this block
//   rst_n       in   synchronous active-low reset
//   pll_lock    in   PLL LOCK output, asynchronous to ref_clk
//   retry_req   in   single-cycle restart request, honoured only in FAIL
//   pll_reset   out  PLL RESET pin, active high
//   chan_rst_n  out  per-domain active-low resets, released staggered in RUN
//   locked      out  high only while running
//   fail        out  high only while parked after exhausting retries
//   retry_cnt   out  retries consumed in the current bring-up sequence
//   lost_cnt    out  lock losses seen while running, saturating at 255
// ---------------------------------------------------------------------------
module dvp_pll_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CH_STAGGER    = 8,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              retry_req,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] chan_rst_n,
    output logic              locked,
    output logic              fail,
    output logic [RW-1:0]     retry_cnt,
    output logic [7:0]        lost_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter times every state, so it must cover the longest interval,
    // including the span of the staggered channel releases.
    localparam int STAGGER_SPAN = (NUM_CH - 1) * CH_STAGGER + 1;
    localparam int CNT_MAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                  max2(STABLE_CYCLES, STAGGER_SPAN));
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle interval is N-1.
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST    = CW'((NUM_CH - 1) * CH_STAGGER);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [RW-1:0]     retry_d;
    logic [7:0]        lost_d;
    logic [NUM_CH-1:0] chan_d;
    logic              lock_meta;
    logic              lock_s;

    // Two-flop synchroniser; nothing downstream looks at pll_lock directly.
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state logic. Within each state the lock_s rule is evaluated
    // before the counter expiry, so a lock change wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_cnt;
        lost_d  = lost_cnt;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_cnt + 1'b1;
                        state_d = RESET_PLL;
                    end
                end
            end

            // A dropout here is treated as a not-yet-settled PLL rather than
            // a failed attempt, so the retry budget is left alone.
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end

            // The counter parks once the last channel has been released.
            RUN: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                    if (lost_cnt != 8'hFF) begin
                        lost_d = lost_cnt + 8'd1;
                    end
                end else if (cnt_q == RUN_LAST) begin
                    cnt_d = cnt_q;
                end
            end

            FAIL: begin
                cnt_d = cnt_q;
                if (retry_req) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (state_d == RUN) begin
            retry_d = '0;
        end
    end

    // Channel k is released once the RUN counter reaches k*CH_STAGGER; the
    // counter holds at the final release point so released channels stay up.
    always_comb begin
        chan_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            chan_d[k] = (state_d == RUN) && (int'(cnt_d) >= k * CH_STAGGER);
        end
    end

    // Outputs are decoded from the next state so that they change on the
    // same edge as the state register itself.
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state_q    <= RESET_PLL;
            cnt_q      <= '0;
            retry_cnt  <= '0;
            lost_cnt   <= '0;
            pll_reset  <= 1'b1;
            chan_rst_n <= '0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_cnt  <= retry_d;
            lost_cnt   <= lost_d;
            pll_reset  <= (state_d == RESET_PLL) || (state_d == FAIL);
            chan_rst_n <= chan_d;
            locked     <= (state_d == RUN);
            fail       <= (state_d == FAIL);
        end
    end

endmodule

// File: tb/tb_dvp_pll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dvp_pll_ctrl
//
// Directed bench for dvp_pll_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRY=2, NUM_CH=3, CH_STAGGER=4. Stimulus pushes
// hand-computed expected output snapshots tagged with the cycle they apply
// to; a monitor on the falling edge pops and compares them.
//
// Cycle numbering: cyc counts rising edges; a snapshot tagged n describes the
// outputs after rising edge n. Inputs change on falling edges, so an input
// set while cyc==n is first sampled by rising edge n+1.
// ---------------------------------------------------------------------------
module tb_dvp_pll_ctrl;

    logic       ref_clk   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       pll_lock  = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_reset;
    logic [2:0] chan_rst_n;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;

    dvp_pll_ctrl #(
        .NUM_CH        (3),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .CH_STAGGER    (4)
    ) dut (
        .ref_clk    (ref_clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .retry_req  (retry_req),
        .pll_reset  (pll_reset),
        .chan_rst_n (chan_rst_n),
        .locked     (locked),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] at;
        logic        pr;
        logic [2:0]  ch;
        logic        lk;
        logic        fl;
        logic [1:0]  rc;
        logic [7:0]  lc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_name;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic applyStimulus(input logic r, input logic l, input logic q);
        rst_n     = r;
        pll_lock  = l;
        retry_req = q;
    endtask

    task automatic pushExpect(input int at, input string nm, input logic pr,
                              input logic [2:0] ch, input logic lk,
                              input logic fl, input logic [1:0] rc,
                              input logic [7:0] lc);
        exp_t e;
        e.at = 32'(at);
        e.pr = pr;
        e.ch = ch;
        e.lk = lk;
        e.fl = fl;
        e.rc = rc;
        e.lc = lc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input exp_t e, input string nm);
        n_checks++;
        if (int'(e.at) != cyc) begin
            n_errors++;
            $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", nm, cyc, int'(e.at));
        end else if ({pll_reset, chan_rst_n, locked, fail, retry_cnt, lost_cnt} !==
                     {e.pr, e.ch, e.lk, e.fl, e.rc, e.lc}) begin
            n_errors++;
            $display("[TB] FAIL %s @%0d: got pll_reset=%b chan=%b locked=%b fail=%b retry=%0d lost=%0d, required pll_reset=%b chan=%b locked=%b fail=%b retry=%0d lost=%0d",
                     nm, cyc, pll_reset, chan_rst_n, locked, fail, retry_cnt, lost_cnt,
                     e.pr, e.ch, e.lk, e.fl, e.rc, e.lc);
        end
    endtask

    always @(negedge ref_clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].at) <= cyc) begin
            mon_e    = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checkOutput(mon_e, mon_name);
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge ref_clk);
    endtask

    // Called on the falling edge where rst_n has just been set to 1 with
    // pll_lock low; raises pll_lock in cycle 10 after release.
    task automatic bringUp(input logic [7:0] lc);
        int b;
        b = cyc;
        pushExpect(b + 3,  "bringup_rst_hold",    1'b1, 3'b000, 1'b0, 1'b0, 2'd0, lc);
        pushExpect(b + 4,  "bringup_rst_release", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, lc);
        pushExpect(b + 20, "bringup_stable_end",  1'b0, 3'b000, 1'b0, 1'b0, 2'd0, lc);
        pushExpect(b + 21, "bringup_run_ch0",     1'b0, 3'b001, 1'b1, 1'b0, 2'd0, lc);
        pushExpect(b + 24, "bringup_ch0_only",    1'b0, 3'b001, 1'b1, 1'b0, 2'd0, lc);
        pushExpect(b + 25, "bringup_ch1",         1'b0, 3'b011, 1'b1, 1'b0, 2'd0, lc);
        pushExpect(b + 28, "bringup_ch1_only",    1'b0, 3'b011, 1'b1, 1'b0, 2'd0, lc);
        pushExpect(b + 29, "bringup_ch2",         1'b0, 3'b111, 1'b1, 1'b0, 2'd0, lc);
        wait_to(b + 10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to(b + 32);
    endtask

    initial begin
        int d;
        int b;
        int f;
        logic [7:0] exp_lost;

        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge ref_clk);
        d = cyc;
        pushExpect(d + 1, "por_reset_values", 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_to(d + 2);

        // Normal bring-up from power-on.
        applyStimulus(1'b1, 1'b0, 1'b0);
        bringUp(8'd0);

        // Lock loss while running, then clean re-lock.
        d = cyc;
        pushExpect(d + 2,  "loss_before",      1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0);
        pushExpect(d + 3,  "loss_chan_drop",   1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1);
        pushExpect(d + 6,  "loss_rst_hold",    1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1);
        pushExpect(d + 7,  "loss_rst_release", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1);
        pushExpect(d + 15, "loss_stable_end",  1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1);
        pushExpect(d + 16, "loss_relock",      1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to(d + 3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to(d + 30);

        // retry_req while running must do nothing.
        d = cyc;
        pushExpect(d + 1, "retry_in_run_a", 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd1);
        pushExpect(d + 2, "retry_in_run_b", 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        wait_to(d + 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to(d + 3);

        // One-cycle reset in the middle of RUN, then a repeat bring-up.
        d = cyc;
        pushExpect(d + 1, "midrun_reset", 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_to(d + 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        bringUp(8'd0);

        // 256 lock losses; the loss counter saturates at 255.
        for (int i = 0; i < 256; i++) begin
            d = cyc;
            applyStimulus(1'b1, 1'b0, 1'b0);
            wait_to(d + 3);
            applyStimulus(1'b1, 1'b1, 1'b0);
            exp_lost = (i >= 254) ? 8'd255 : 8'(i + 1);
            pushExpect(d + 17, "loss_count", 1'b0, 3'b001, 1'b1, 1'b0, 2'd0, exp_lost);
            wait_to(d + 17);
        end

        // Reset clears the saturated loss counter; lock is already present,
        // then a 3-cycle glitch during STABLE restarts the qualification.
        d = cyc;
        pushExpect(d + 1, "reset_clears_lost", 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_to(d + 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        b = cyc;
        pushExpect(b + 9,  "glitch_stable",          1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(b + 12, "glitch_retry_unchanged", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(b + 13, "glitch_no_early_run",    1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(b + 20, "glitch_stable_end",      1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(b + 21, "glitch_run",             1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0);
        wait_to(b + 7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to(b + 10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to(b + 24);

        // PLL never locks: three attempts, then parked in FAIL.
        d = cyc;
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_to(d + 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        b = cyc;
        pushExpect(b + 35,  "try1_wait_last", 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(b + 36,  "try1_timeout",   1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0);
        pushExpect(b + 39,  "try2_rst_hold",  1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0);
        pushExpect(b + 40,  "try2_wait",      1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0);
        pushExpect(b + 72,  "try2_timeout",   1'b1, 3'b000, 1'b0, 1'b0, 2'd2, 8'd0);
        pushExpect(b + 107, "try3_wait_last", 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 8'd0);
        pushExpect(b + 108, "fail_entry",     1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd0);
        pushExpect(b + 150, "fail_hold",      1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd0);
        wait_to(b + 20);
        applyStimulus(1'b1, 1'b0, 1'b1);
        wait_to(b + 21);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to(b + 150);

        // retry_req in FAIL restarts the sequence with a fresh retry budget.
        f = cyc;
        pushExpect(f + 1,  "retry_restart",  1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(f + 4,  "retry_rst_hold", 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(f + 5,  "retry_wait",     1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        pushExpect(f + 14, "retry_run",      1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        wait_to(f + 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to(f + 24);

        d = cyc;
        while (exp_q.size() > 0 && cyc < d + 10) @(negedge ref_clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL pending_checks: %0d left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: cycle %0d reached without finishing, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
